// File: rtl/zion_pc_gen_pkg.sv
// zion_pc_gen_pkg
//   Shared types and constants for the fetch-PC generator.
//   XLEN()          : PC width for a given RV64 selector (32 or 64).
//   pc_gen_state_e  : fetch FSM states.
//   REDIRECT_CNT_W  : width of the saturating redirect counter.
package zion_pc_gen_pkg;

   localparam int REDIRECT_CNT_W = 16;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } pc_gen_state_e;

   function automatic int XLEN(input int rv64);
      return 32 * (1 + rv64);
   endfunction

endpackage

// File: rtl/zion_pc_set_arbiter.sv
// zion_pc_set_arbiter
//   Combinational fixed-priority selector over the PC-set channels.
//   Channel 0 has the highest priority. The selected target has its low
//   ALIGN_BITS bits cleared so fetch never sees a misaligned PC.
// Ports:
//   iPcSetEn   : per-channel set enable
//   iPcSetTgt  : packed per-channel targets, channel k at [k*PC_W +: PC_W]
//   oAnySet    : at least one channel is requesting a redirect
//   oSelTgt    : aligned target of the winning channel (0 when none)
module zion_pc_set_arbiter #(
   parameter int CH_NUM     = 3,
   parameter int PC_W       = 32,
   parameter int ALIGN_BITS = 2
) (
   input  logic [CH_NUM-1:0]      iPcSetEn,
   input  logic [CH_NUM*PC_W-1:0] iPcSetTgt,
   output logic                   oAnySet,
   output logic [PC_W-1:0]        oSelTgt
);

   localparam logic [PC_W-1:0] ALIGN_MASK = {PC_W{1'b1}} << ALIGN_BITS;

   logic [PC_W-1:0] rawTgt;

   // Walk from the lowest-priority channel upward so the last hit,
   // i.e. the lowest index, is the one that sticks.
   always_comb begin
      oAnySet = 1'b0;
      rawTgt  = '0;
      for (int k = CH_NUM - 1; k >= 0; k--) begin
         if (iPcSetEn[k]) begin
            oAnySet = 1'b1;
            rawTgt  = iPcSetTgt[k*PC_W +: PC_W];
         end
      end
      oSelTgt = rawTgt & ALIGN_MASK;
   end

endmodule

// File: rtl/zion_pc_gen.sv
// zion_pc_gen
//   Holds the architectural fetch PC and offers it to instruction fetch
//   over a valid/ready handshake. The PC advances by INST_BYTES on each
//   accepted fetch and is overwritten by the highest-priority PC-set
//   channel, which always wins over a same-cycle increment.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   iPcSetEn      : per-channel set enable (channel 0 highest priority)
//   iPcSetTgt     : packed per-channel target PCs
//   iHalt         : stop offering fetches; PC held (redirects still land)
//   iFetchRdy     : fetch accepts oFetchPc this cycle
//   oFetchVld     : oFetchPc is valid (registered, RUN state only)
//   oFetchPc      : current fetch PC
//   oRedirect     : one-cycle pulse after a set-channel overwrite
//   oRedirectCnt  : saturating count of redirects since reset
module zion_pc_gen
   import zion_pc_gen_pkg::*;
#(
   parameter int          RV64       = 0,
   parameter int          CH_NUM     = 3,
   parameter logic [63:0] RESET_PC   = 64'h8000_0000,
   parameter int          INST_BYTES = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [CH_NUM-1:0]                    iPcSetEn,
   input  logic [CH_NUM*zion_pc_gen_pkg::XLEN(RV64)-1:0] iPcSetTgt,
   input  logic                                 iHalt,
   input  logic                                 iFetchRdy,
   output logic                                 oFetchVld,
   output logic [zion_pc_gen_pkg::XLEN(RV64)-1:0] oFetchPc,
   output logic                                 oRedirect,
   output logic [REDIRECT_CNT_W-1:0]            oRedirectCnt
);

   localparam int PC_W       = zion_pc_gen_pkg::XLEN(RV64);
   localparam int ALIGN_BITS = $clog2(INST_BYTES);
   localparam logic [PC_W-1:0] PC_RST  = RESET_PC[PC_W-1:0];
   localparam logic [PC_W-1:0] PC_STEP = PC_W'(INST_BYTES);

   pc_gen_state_e   state;
   logic [PC_W-1:0] pcQ;
   logic            anySet;
   logic [PC_W-1:0] selTgt;
   logic            fetchAccept;

   zion_pc_set_arbiter #(
      .CH_NUM     (CH_NUM),
      .PC_W       (PC_W),
      .ALIGN_BITS (ALIGN_BITS)
   ) uArb (
      .iPcSetEn  (iPcSetEn),
      .iPcSetTgt (iPcSetTgt),
      .oAnySet   (anySet),
      .oSelTgt   (selTgt)
   );

   assign fetchAccept = (state == RUN) && oFetchVld && iFetchRdy;
   assign oFetchPc    = pcQ;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= BOOT;
         pcQ          <= PC_RST;
         oFetchVld    <= 1'b0;
         oRedirect    <= 1'b0;
         oRedirectCnt <= '0;
      end else begin
         // Every state leaves for HALT while iHalt is up and for RUN
         // otherwise; valid is registered alongside so it tracks RUN.
         case (state)
            BOOT, RUN, HALT: begin
               state     <= iHalt ? HALT : RUN;
               oFetchVld <= !iHalt;
            end
            default: begin
               state     <= HALT;
               oFetchVld <= 1'b0;
            end
         endcase

         // A redirect is a flush: it replaces the PC even if fetch took
         // the current one this cycle, so no increment is applied.
         if (anySet)
            pcQ <= selTgt;
         else if (fetchAccept)
            pcQ <= pcQ + PC_STEP;

         oRedirect <= anySet;
         if (anySet && (oRedirectCnt != {REDIRECT_CNT_W{1'b1}}))
            oRedirectCnt <= oRedirectCnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_zion_pc_gen.sv
module tb_zion_pc_gen;

   localparam int CH_NUM = 3;
   localparam int XL     = 32;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic [CH_NUM-1:0]      en  = '0;
   logic [CH_NUM*XL-1:0]   tgt = '0;
   logic                   halt = 1'b0;
   logic                   rdy  = 1'b0;
   logic                   vld;
   logic [XL-1:0]          pc;
   logic                   redir;
   logic [15:0]            cnt;

   int nChecks = 0;
   int nFails  = 0;

   zion_pc_gen #(
      .RV64       (0),
      .CH_NUM     (CH_NUM),
      .RESET_PC   (64'h8000_0000),
      .INST_BYTES (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .iPcSetEn     (en),
      .iPcSetTgt    (tgt),
      .iHalt        (halt),
      .iFetchRdy    (rdy),
      .oFetchVld    (vld),
      .oFetchPc     (pc),
      .oRedirect    (redir),
      .oRedirectCnt (cnt)
   );

   always #5 clk = ~clk;

   // Reference model: PC offered to fetch, whether an offer is out,
   // last-cycle redirect flag and a plain integer redirect count.
   longint mPc;
   bit     mVld;
   bit     mRedir;
   int     mCnt;
   int     mHit;
   longint mT;

   always @(posedge clk) begin
      if (rst) begin
         mPc    <= 64'h8000_0000;
         mVld   <= 1'b0;
         mRedir <= 1'b0;
         mCnt   <= 0;
      end else begin
         mHit = -1;
         for (int k = 0; k < CH_NUM; k++)
            if (en[k] && mHit < 0) mHit = k;
         if (mHit >= 0) begin
            mT = longint'(tgt[mHit*XL +: XL]);
            mPc <= mT - (mT % 4);
         end else if (mVld && rdy) begin
            mPc <= (mPc + 4) % 64'h1_0000_0000;
         end
         mVld   <= !halt;
         mRedir <= (mHit >= 0);
         mCnt   <= (mHit >= 0) ? ((mCnt + 1 > 65535) ? 65535 : mCnt + 1) : mCnt;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst = 1'b1; en = '0; tgt = '0; halt = 1'b0; rdy = 1'b0;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      doReset();
      rdy = 1'b1;
      nChecks++;
      if (vld !== 1'b0 || pc !== 32'h8000_0000 || redir !== 1'b0 || cnt !== 16'h0) begin
         nFails++;
         $display("FAIL reset_state: vld=%0b pc=%h redir=%0b cnt=%h want 0 80000000 0 0", vld, pc, redir, cnt);
      end
      step();
      nChecks++;
      if (vld !== 1'b1 || pc !== 32'h8000_0000) begin
         nFails++;
         $display("FAIL first_fetch: vld=%0b pc=%h want 1 80000000", vld, pc);
      end
      for (int i = 1; i <= 2; i++) begin
         step();
         nChecks++;
         if (pc !== 32'h8000_0000 + 32'(4 * i)) begin
            nFails++;
            $display("FAIL seq_pc%0d: pc=%h want %h", i, pc, 32'h8000_0000 + 32'(4 * i));
         end
      end
   endtask

   task automatic test_backpressure();
      step(); step();   // 0x0C, 0x10
      nChecks++;
      if (pc !== 32'h8000_0010) begin
         nFails++;
         $display("FAIL bp_setup: pc=%h want 80000010", pc);
      end
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         nChecks++;
         if (pc !== 32'h8000_0010 || vld !== 1'b1) begin
            nFails++;
            $display("FAIL bp_hold%0d: pc=%h vld=%0b want 80000010 1", i, pc, vld);
         end
      end
      rdy = 1'b1;
      step();
      nChecks++;
      if (pc !== 32'h8000_0014) begin
         nFails++;
         $display("FAIL bp_release: pc=%h want 80000014", pc);
      end
   endtask

   task automatic test_priority();
      doReset();
      en = 3'b110;
      tgt[1*XL +: XL] = 32'h1000;
      tgt[2*XL +: XL] = 32'h2000;
      step();
      nChecks++;
      if (pc !== 32'h1000 || redir !== 1'b1 || cnt !== 16'd1) begin
         nFails++;
         $display("FAIL prio_sel: pc=%h redir=%0b cnt=%0d want 1000 1 1", pc, redir, cnt);
      end
      en = '0;
      step();
      nChecks++;
      if (redir !== 1'b0 || cnt !== 16'd1 || pc !== 32'h1000) begin
         nFails++;
         $display("FAIL prio_pulse: pc=%h redir=%0b cnt=%0d want 1000 0 1", pc, redir, cnt);
      end
      en = 3'b111;
      tgt[0*XL +: XL] = 32'h3003;
      step();
      nChecks++;
      if (pc !== 32'h3000 || cnt !== 16'd2) begin
         nFails++;
         $display("FAIL prio_align: pc=%h cnt=%0d want 3000 2", pc, cnt);
      end
      en = '0;
   endtask

   task automatic test_redirect_halt();
      doReset();
      en = 3'b001; tgt[0 +: XL] = 32'h100;
      step();
      rdy = 1'b1; tgt[0 +: XL] = 32'h400;
      step();
      nChecks++;
      if (pc !== 32'h400) begin
         nFails++;
         $display("FAIL redir_vs_accept: pc=%h want 400", pc);
      end
      en = '0; halt = 1'b1;
      step();
      nChecks++;
      if (pc !== 32'h404 || vld !== 1'b0) begin
         nFails++;
         $display("FAIL halt_entry_accept: pc=%h vld=%0b want 404 0", pc, vld);
      end
      en = 3'b010; tgt[1*XL +: XL] = 32'h400;
      step();
      nChecks++;
      if (pc !== 32'h400 || vld !== 1'b0 || redir !== 1'b1) begin
         nFails++;
         $display("FAIL halt_redirect: pc=%h vld=%0b redir=%0b want 400 0 1", pc, vld, redir);
      end
      en = '0;
      step();
      nChecks++;
      if (pc !== 32'h400 || vld !== 1'b0) begin
         nFails++;
         $display("FAIL halt_hold: pc=%h vld=%0b want 400 0", pc, vld);
      end
      halt = 1'b0;
      step();
      nChecks++;
      if (pc !== 32'h400 || vld !== 1'b1) begin
         nFails++;
         $display("FAIL halt_resume: pc=%h vld=%0b want 400 1", pc, vld);
      end
      step();
      nChecks++;
      if (pc !== 32'h404) begin
         nFails++;
         $display("FAIL resume_adv: pc=%h want 404", pc);
      end
   endtask

   task automatic test_wrap();
      doReset();
      en = 3'b001; tgt[0 +: XL] = 32'hFFFF_FFFC;
      step();
      en = '0; rdy = 1'b1;
      nChecks++;
      if (pc !== 32'hFFFF_FFFC || vld !== 1'b1) begin
         nFails++;
         $display("FAIL wrap_setup: pc=%h vld=%0b want fffffffc 1", pc, vld);
      end
      step();
      nChecks++;
      if (pc !== 32'h0) begin
         nFails++;
         $display("FAIL wrap: pc=%h want 00000000", pc);
      end
   endtask

   task automatic test_saturation();
      doReset();
      en = 3'b100;
      for (int i = 0; i < 65534; i++) begin
         tgt[2*XL +: XL] = $urandom;
         step();
      end
      nChecks++;
      if (cnt !== 16'hFFFE) begin
         nFails++;
         $display("FAIL sat_pre: cnt=%h want fffe", cnt);
      end
      step();
      nChecks++;
      if (cnt !== 16'hFFFF) begin
         nFails++;
         $display("FAIL sat_reach: cnt=%h want ffff", cnt);
      end
      step();
      nChecks++;
      if (cnt !== 16'hFFFF || redir !== 1'b1) begin
         nFails++;
         $display("FAIL sat_hold: cnt=%h redir=%0b want ffff 1", cnt, redir);
      end
      en = '0;
   endtask

   task automatic test_reset_mid();
      doReset();
      rdy = 1'b1;
      en = 3'b001; tgt[0 +: XL] = 32'h500;
      step(); step();
      rst = 1'b1;
      step();
      nChecks++;
      if (pc !== 32'h8000_0000 || cnt !== 16'h0 || redir !== 1'b0 || vld !== 1'b0) begin
         nFails++;
         $display("FAIL reset_mid: pc=%h cnt=%h redir=%0b vld=%0b want 80000000 0 0 0", pc, cnt, redir, vld);
      end
      rst = 1'b0; en = '0;
   endtask

   task automatic test_random();
      doReset();
      for (int i = 0; i < 2000; i++) begin
         rst  = ($urandom_range(0, 63) == 0);
         en   = ($urandom_range(0, 3) == 0) ? CH_NUM'($urandom) : '0;
         for (int k = 0; k < CH_NUM; k++) tgt[k*XL +: XL] = $urandom;
         halt = ($urandom_range(0, 7) == 0);
         rdy  = ($urandom_range(0, 3) != 0);
         step();
         nChecks++;
         if (pc !== mPc[XL-1:0] || vld !== mVld || redir !== mRedir || cnt !== 16'(mCnt)) begin
            nFails++;
            $display("FAIL random%0d: pc=%h vld=%0b redir=%0b cnt=%0d want %h %0b %0b %0d",
                     i, pc, vld, redir, cnt, mPc[XL-1:0], mVld, mRedir, mCnt);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_backpressure();
      test_priority();
      test_redirect_halt();
      test_wrap();
      test_saturation();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
